// File: rtl/gc_response_rx.sv
// GameCube response receiver: pulse-width decode of NUM_BITS + stop bit; optional GC_RX_GLITCH_FILTER_EN majority filter.
// Latency 3 cycles from stop-bit rise to resp_valid (+2 with filter); no backpressure, strobes are fire-and-forget.
module gc_response_rx #(
  parameter int NUM_BITS      = 64,
  parameter int LOW_MIN       = 50,
  parameter int LOW_THRESH    = 200,
  parameter int LOW_MAX       = 350,
  parameter int HIGH_MAX      = 500,
  parameter int START_TIMEOUT = 10000
) (
  input  logic                clk100mhz,
  input  logic                reset,
  input  logic                data_in,
  input  logic                arm,
  output logic [NUM_BITS-1:0] resp_data,
  output logic                resp_valid,
  output logic                resp_error,
  output logic [1:0]          err_code,
  output logic                busy
);

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] NUM_BITS_C      = CW'(NUM_BITS);
  localparam logic [15:0]   LOW_MIN_C       = 16'(LOW_MIN);
  localparam logic [15:0]   LOW_THRESH_C    = 16'(LOW_THRESH);
  localparam logic [15:0]   LOW_MAX_C       = 16'(LOW_MAX);
  localparam logic [15:0]   HIGH_MAX_C      = 16'(HIGH_MAX);
  localparam logic [15:0]   START_TIMEOUT_C = 16'(START_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_LOW, S_HIGH, S_DONE, S_ERR
  } state_t;

  // Synchronizer flops reset high so a released bus does not look like a falling edge.
  logic sync1_q, sync2_q, line_s, prev_q;

  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef GC_RX_GLITCH_FILTER_EN
  logic hist1_q, hist2_q, filt_q;

  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
      filt_q  <= 1'b1;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
      filt_q  <= (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
    end
  end

  assign line_s = filt_q;
`else
  assign line_s = sync2_q;
`endif

  always_ff @(posedge clk100mhz) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= line_s;
  end

  logic fall, rise;
  assign fall = prev_q & ~line_s;
  assign rise = ~prev_q & line_s;

  state_t              state_q;
  logic [NUM_BITS-1:0] shift_q, resp_data_q;
  logic [CW-1:0]       bit_cnt_q;
  logic [15:0]         low_cnt_q, high_cnt_q, timer_q;
  logic                resp_valid_q, resp_error_q, busy_q;
  logic [1:0]          err_code_q;

  // low_cnt_d is the width including the current sample; all width decisions use it.
  logic [15:0] low_cnt_d, high_cnt_d, timer_d;
  logic        bit_val;
  assign low_cnt_d  = (low_cnt_q == 16'hFFFF) ? low_cnt_q : low_cnt_q + 16'd1;
  assign high_cnt_d = high_cnt_q + 16'd1;
  assign timer_d    = timer_q + 16'd1;
  assign bit_val    = (low_cnt_d < LOW_THRESH_C);

  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      resp_data_q  <= '0;
      bit_cnt_q    <= '0;
      low_cnt_q    <= '0;
      high_cnt_q   <= '0;
      timer_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      err_code_q   <= 2'd0;
      busy_q       <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (fall) begin
            low_cnt_q <= '0;
            state_q   <= S_LOW;
          end else if (timer_d == START_TIMEOUT_C) begin
            resp_error_q <= 1'b1;
            err_code_q   <= 2'd1;
            state_q      <= S_ERR;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_LOW: begin
          low_cnt_q <= low_cnt_d;
          if (rise) begin
            if (low_cnt_d < LOW_MIN_C || low_cnt_d > LOW_MAX_C) begin
              resp_error_q <= 1'b1;
              err_code_q   <= 2'd2;
              state_q      <= S_ERR;
            end else if (bit_cnt_q < NUM_BITS_C) begin
              shift_q    <= {shift_q[NUM_BITS-2:0], bit_val};
              bit_cnt_q  <= bit_cnt_q + CW'(1);
              high_cnt_q <= '0;
              state_q    <= S_HIGH;
            end else if (bit_val) begin
              resp_data_q  <= shift_q;
              resp_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              resp_error_q <= 1'b1;
              err_code_q   <= 2'd3;
              state_q      <= S_ERR;
            end
          end else if (low_cnt_d > LOW_MAX_C) begin
            resp_error_q <= 1'b1;
            err_code_q   <= 2'd2;
            state_q      <= S_ERR;
          end
        end
        S_HIGH: begin
          if (fall) begin
            low_cnt_q <= '0;
            state_q   <= S_LOW;
          end else if (high_cnt_d == HIGH_MAX_C) begin
            resp_error_q <= 1'b1;
            err_code_q   <= 2'd3;
            state_q      <= S_ERR;
          end else begin
            high_cnt_q <= high_cnt_d;
          end
        end
        S_DONE, S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_data  = resp_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign err_code   = err_code_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gc_response_rx.sv
// Directed bench for gc_response_rx: drives pulse-width frames on data_in and checks the decoded word and strobes.
module tb_gc_response_rx;

  logic        clk100mhz = 1'b0;
  logic        reset     = 1'b1;
  logic        data_in   = 1'b1;
  logic        arm       = 1'b0;
  logic [63:0] resp_data;
  logic        resp_valid, resp_error, busy;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int t;
  int v0, e0;

`ifdef GC_RX_GLITCH_FILTER_EN
  localparam int XL = 2;
`else
  localparam int XL = 0;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  gc_response_rx dut (
    .clk100mhz (clk100mhz),
    .reset     (reset),
    .data_in   (data_in),
    .arm       (arm),
    .resp_data (resp_data),
    .resp_valid(resp_valid),
    .resp_error(resp_error),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk100mhz = ~clk100mhz;

  always @(negedge clk100mhz) begin
    if (resp_valid) n_valid++;
    if (resp_error) n_err++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100mhz);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send_bit(input int lo, input int hi);
    data_in = 1'b0;
    repeat (lo) tick();
    data_in = 1'b1;
    repeat (hi) tick();
  endtask

  // Bits hi_idx down to lo_idx of w; slow selects the 100/300 and 300/100 timing, else 50-cycle highs.
  task automatic send_word(input logic [63:0] w, input int hi_idx, input int lo_idx, input bit slow);
    for (int i = hi_idx; i >= lo_idx; i--) begin
      if (w[i]) send_bit(100, slow ? 300 : 50);
      else      send_bit(300, slow ? 100 : 50);
    end
  endtask

  task automatic wait_strobe(input int max, output int ticks);
    ticks = 0;
    while (!(resp_valid || resp_error) && ticks < max) begin
      tick();
      ticks++;
    end
  endtask

  task automatic stop_bit(output int lat);
    data_in = 1'b0;
    repeat (100) tick();
    data_in = 1'b1;
    wait_strobe(50, lat);
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_data",  resp_data, 64'd0);
    check_eq("rst_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_error", 64'(resp_error), 64'd0);
    check_eq("rst_code",  64'(err_code), 64'd0);
    check_eq("rst_busy",  64'(busy), 64'd0);
    reset = 1'b0;
    tick();

    // Alternating frame with nominal timing.
    v0 = n_valid;
    arm_pulse();
    check_eq("arm_busy", 64'(busy), 64'd1);
    repeat (20) tick();
    send_word(64'hAAAA_AAAA_AAAA_AAAA, 63, 0, 1'b1);
    stop_bit(t);
    check_eq("alt_latency", 64'(t), 64'(3 + XL));
    check_eq("alt_valid", 64'(resp_valid), 64'd1);
    check_eq("alt_data", resp_data, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    check_eq("alt_busy_after", 64'(busy), 64'd0);
    check_eq("alt_valid_one_cycle", 64'(resp_valid), 64'd0);
    repeat (5) tick();
    check_eq("alt_valid_count", 64'(n_valid - v0), 64'd1);

    // Start timeout with the line idle high.
    arm_pulse();
    wait_strobe(10100, t);
    check_eq("to_cycles", 64'(t), 64'd10000);
    check_eq("to_error", 64'(resp_error), 64'd1);
    check_eq("to_code", 64'(err_code), 64'd1);
    check_eq("to_data_kept", resp_data, 64'hAAAA_AAAA_AAAA_AAAA);
    repeat (5) tick();

    // Overlong low on bit 5: error fires while the line is still low.
    arm_pulse();
    repeat (10) tick();
    send_word(ONES, 63, 59, 1'b0);
    data_in = 1'b0;
    wait_strobe(400, t);
    check_eq("long_cycles", 64'(t), 64'(354 + XL));
    check_eq("long_error", 64'(resp_error), 64'd1);
    check_eq("long_code", 64'(err_code), 64'd2);
    check_eq("long_line_low", 64'(data_in), 64'd0);
    data_in = 1'b1;
    repeat (10) tick();

    // Truncated 40-bit frame, then recovery with a good frame.
    arm_pulse();
    repeat (10) tick();
    send_word(ONES, 63, 25, 1'b0);
    data_in = 1'b0;
    repeat (100) tick();
    data_in = 1'b1;
    wait_strobe(600, t);
    check_eq("trunc_cycles", 64'(t), 64'(503 + XL));
    check_eq("trunc_code", 64'(err_code), 64'd3);
    check_eq("trunc_data_kept", resp_data, 64'hAAAA_AAAA_AAAA_AAAA);
    repeat (5) tick();
    arm_pulse();
    repeat (10) tick();
    send_word(64'h0123_4567_89AB_CDEF, 63, 0, 1'b0);
    stop_bit(t);
    check_eq("recov_valid", 64'(resp_valid), 64'd1);
    check_eq("recov_data", resp_data, 64'h0123_4567_89AB_CDEF);
    repeat (5) tick();

    // Width boundaries: 199 -> 1, 200 -> 0, 50 -> 1, 350 -> 0.
    arm_pulse();
    repeat (10) tick();
    send_bit(199, 50);
    send_bit(200, 50);
    arm = 1'b1;          // ignored outside IDLE
    send_bit(50, 50);
    arm = 1'b0;
    send_bit(350, 50);
    send_word(ONES, 59, 0, 1'b0);
    stop_bit(t);
    check_eq("bnd_valid", 64'(resp_valid), 64'd1);
    check_eq("bnd_data", resp_data, 64'hAFFF_FFFF_FFFF_FFFF);
    repeat (5) tick();

    arm_pulse();
    repeat (10) tick();
    data_in = 1'b0;
    repeat (49) tick();
    data_in = 1'b1;
    wait_strobe(50, t);
    check_eq("short_error", 64'(resp_error), 64'd1);
    check_eq("short_code", 64'(err_code), 64'd2);
    repeat (5) tick();

    // Reset in the middle of bit 30 aborts silently.
    v0 = n_valid;
    e0 = n_err;
    arm_pulse();
    repeat (10) tick();
    send_word(ONES, 63, 34, 1'b0);
    data_in = 1'b0;
    repeat (50) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_data", resp_data, 64'd0);
    check_eq("midrst_code", 64'(err_code), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    data_in = 1'b1;
    repeat (600) tick();
    check_eq("midrst_no_strobe", 64'((n_valid - v0) + (n_err - e0)), 64'd0);

    reset = 1'b1;
    arm   = 1'b1;
    tick();
    reset = 1'b0;
    arm   = 1'b0;
    repeat (20) tick();
    check_eq("rst_arm_busy", 64'(busy), 64'd0);

`ifdef GC_RX_GLITCH_FILTER_EN
    // One-cycle spike inside a 300-cycle low must not split the bit.
    arm_pulse();
    repeat (10) tick();
    data_in = 1'b0;
    repeat (150) tick();
    data_in = 1'b1;
    tick();
    data_in = 1'b0;
    repeat (149) tick();
    data_in = 1'b1;
    repeat (50) tick();
    send_word(ONES, 62, 0, 1'b0);
    stop_bit(t);
    check_eq("glitch_valid", 64'(resp_valid), 64'd1);
    check_eq("glitch_data", resp_data, 64'h7FFF_FFFF_FFFF_FFFF);
    repeat (5) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
